bomb_fuse_timer: RTL and testbench

- Parametrised multi-digit down-counting timer for bomb fuses and round clocks. Generalises the single-digit down counter to N chained digits with a configurable radix.
- Adds explicit run control, a selectable expiry mode (stop-at-zero or auto-reload) and a one-cycle expiry pulse.
- Sits between the game tick generator and the bomb/explosion logic and the score/time display.

---
 rtl/bomb_fuse_timer_pkg.sv | 26 ++
 rtl/bomb_fuse_timer_if.sv | 29 ++
 rtl/bomb_fuse_timer_bcd_digit_down.sv | 45 ++++
 rtl/bomb_fuse_timer.sv | 155 +++++++++++++++
 tb/tb_bomb_fuse_timer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/bomb_fuse_timer_pkg.sv
// Shared types and constants for the bomb fuse timer: FSM state encoding,
// digit width and the per-digit clamp helper used on loaded values.
package bomb_timer_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  // Limit one nibble to the legal digit range 0..base-1.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                     input int base);
    logic [DIGIT_W-1:0] r;
    if (int'(d) >= base) begin
      r = DIGIT_W'(base - 1);
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bomb_fuse_timer_if.sv
// Control/status bundle between the tick/game logic and the fuse timer.
// The controller side (master) drives run control and load data; the timer
// side (slave) returns the packed count and status flags.
interface bomb_fuse_timer_if #(
  parameter int DIGITS = 2
);

  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  start;
  logic                  stop;
  logic                  tick;
  logic                  auto_reload;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  expired;
  logic                  running;

  modport master (
    output load, load_value, start, stop, tick, auto_reload,
    input  count, tc, expired, running
  );

  modport slave (
    input  load, load_value, start, stop, tick, auto_reload,
    output count, tc, expired, running
  );

endinterface

// File: rtl/bomb_fuse_timer_bcd_digit_down.sv
// One down-counting digit of configurable radix. Wraps from 0 to BASE-1 and
// raises borrow_out when it is asked to decrement while already at 0, which
// enables the next more significant digit.
module bcd_digit_down
  import bomb_timer_pkg::*;
#(
  parameter int                 BASE       = 10,
  parameter logic [DIGIT_W-1:0] INIT_DIGIT = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               dec_en,
  output logic [DIGIT_W-1:0] digit,
  output logic               zero,
  output logic               borrow_out
);

  localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(BASE - 1);

  logic [DIGIT_W-1:0] digit_r;

  // Digit register: reset, load, then borrow-driven decrement with wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_r <= INIT_DIGIT;
    end else if (load) begin
      digit_r <= load_digit;
    end else if (dec_en) begin
      if (digit_r == 4'd0) begin
        digit_r <= MAX_DIGIT;
      end else begin
        digit_r <= digit_r - 4'd1;
      end
    end else begin
      digit_r <= digit_r;
    end
  end

  assign digit      = digit_r;
  assign zero       = (digit_r == 4'd0);
  assign borrow_out = dec_en & zero;

endmodule

// File: rtl/bomb_fuse_timer.sv
// Multi-digit fuse / round timer. Holds the run-control FSM, the reload
// register and the expiry pulse; the digits themselves are a borrow chain
// of bcd_digit_down instances.
module bomb_fuse_timer
  import bomb_timer_pkg::*;
#(
  parameter int                      DIGITS     = 2,
  parameter int                      BASE       = 10,
  parameter logic [4*DIGITS-1:0]     INIT_VALUE = 8'h30
) (
  input  logic              clk,
  input  logic              reset,
  bomb_fuse_timer_if.slave  bus
);

  localparam int CW = DIGIT_W * DIGITS;

  // Clamp every nibble of a packed word into 0..BASE-1.
  function automatic logic [CW-1:0] clamp_word(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DIGIT_W +: DIGIT_W] = clamp_digit(v[i*DIGIT_W +: DIGIT_W], BASE);
    end
    return r;
  endfunction

  localparam logic [CW-1:0] INIT_CLAMPED = clamp_word(INIT_VALUE);
  localparam logic [CW-1:0] ONE_WORD     = {{(CW-1){1'b0}}, 1'b1};

  timer_state_t   state_r;
  timer_state_t   state_s;
  logic [CW-1:0]  reload_r;
  logic           expired_r;
  logic           expired_s;
  logic           dec_s;
  logic           reload_now_s;
  logic           digit_load_s;
  logic [CW-1:0]  digit_load_word_s;
  logic [CW-1:0]  count_s;
  logic           count_zero_s;
  logic [DIGITS-1:0] zero_s;
  logic [DIGITS:0]   borrow_s;

  assign count_zero_s = &zero_s;

  // Next-state, decrement and expiry decisions in priority order:
  // load > stop > start > tick (reset is handled in the registers).
  always_comb begin
    state_s      = state_r;
    dec_s        = 1'b0;
    reload_now_s = 1'b0;
    expired_s    = 1'b0;
    if (bus.load) begin
      state_s = IDLE;
    end else if (bus.stop) begin
      case (state_r)
        RUN:     state_s = PAUSE;
        PAUSE:   state_s = PAUSE;
        IDLE:    state_s = IDLE;
        DONE:    state_s = DONE;
        default: state_s = IDLE;
      endcase
    end else if (bus.start) begin
      case (state_r)
        IDLE:    state_s = RUN;
        PAUSE:   state_s = RUN;
        RUN:     state_s = RUN;
        DONE:    state_s = DONE;
        default: state_s = IDLE;
      endcase
    end else if (bus.tick && (state_r == RUN)) begin
      if (count_zero_s) begin
        // Already at zero (e.g. loaded 0): reload or finish, never pulse.
        if (bus.auto_reload) begin
          reload_now_s = 1'b1;
        end else begin
          state_s = DONE;
        end
      end else begin
        dec_s = 1'b1;
        if (count_s == ONE_WORD) begin
          expired_s = 1'b1;
          if (bus.auto_reload) begin
            state_s = RUN;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = RUN;
        end
      end
    end else begin
      state_s = state_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Reload register: captures the clamped load value.
  always_ff @(posedge clk) begin
    if (reset) begin
      reload_r <= INIT_CLAMPED;
    end else if (bus.load) begin
      reload_r <= clamp_word(bus.load_value);
    end else begin
      reload_r <= reload_r;
    end
  end

  // Expiry pulse, registered on the same edge as the count reaching zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      expired_r <= 1'b0;
    end else if (bus.load) begin
      expired_r <= 1'b0;
    end else begin
      expired_r <= expired_s;
    end
  end

  // Digits load either from the bus (explicit load) or from the reload register.
  assign digit_load_s      = bus.load | reload_now_s;
  assign digit_load_word_s = bus.load ? clamp_word(bus.load_value) : reload_r;
  assign borrow_s[0]       = dec_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_down #(
      .BASE       (BASE),
      .INIT_DIGIT (INIT_CLAMPED[g*DIGIT_W +: DIGIT_W])
    ) u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (digit_load_s),
      .load_digit (digit_load_word_s[g*DIGIT_W +: DIGIT_W]),
      .dec_en     (borrow_s[g]),
      .digit      (count_s[g*DIGIT_W +: DIGIT_W]),
      .zero       (zero_s[g]),
      .borrow_out (borrow_s[g+1])
    );
  end

  assign bus.count   = count_s;
  assign bus.tc      = count_zero_s;
  assign bus.expired = expired_r;
  assign bus.running = (state_r == RUN);

endmodule

// File: tb/tb_bomb_fuse_timer.sv
// Directed bench for bomb_fuse_timer: each step drives one cycle of inputs,
// pushes the expected post-edge outputs to a scoreboard queue, and pops and
// checks them one time unit after the clock edge.
module tb_bomb_fuse_timer;

  typedef struct {
    string      tag;
    logic [7:0] count;
    logic       expired;
    logic       running;
    logic       tc;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];

  bomb_fuse_timer_if #(.DIGITS(2)) bus ();

  bomb_fuse_timer #(
    .DIGITS     (2),
    .BASE       (10),
    .INIT_VALUE (8'h30)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input string what,
                           input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s.%s observed=%0b expected=%0b", tag, what, obs, expv);
    end
  endtask

  // One clock: drive inputs, push expectation, wait edge, pop and compare.
  task automatic cyc(input logic rst, input logic ld, input logic [7:0] lv,
                     input logic st, input logic sp, input logic tk,
                     input logic ar, input string tag,
                     input logic [7:0] ec, input logic ee, input logic er);
    exp_t e;
    exp_t got;
    reset           = rst;
    bus.load        = ld;
    bus.load_value  = lv;
    bus.start       = st;
    bus.stop        = sp;
    bus.tick        = tk;
    bus.auto_reload = ar;
    e.tag = tag; e.count = ec; e.expired = ee; e.running = er;
    e.tc  = (ec == 8'h00);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    total++;
    assert (bus.count === got.count) else begin
      bad++;
      $error("FAIL %s.count observed=%h expected=%h", got.tag, bus.count, got.count);
    end
    check_bit(got.tag, "expired", bus.expired, got.expired);
    check_bit(got.tag, "running", bus.running, got.running);
    check_bit(got.tag, "tc",      bus.tc,      got.tc);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.load = 1'b0; bus.load_value = 8'h00; bus.start = 1'b0;
    bus.stop = 1'b0; bus.tick = 1'b0; bus.auto_reload = 1'b0;
    @(negedge clk);

    //   rst   ld    lv     st    sp    tk    ar    tag          count  exp   run
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "reset",     8'h30, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "idle_tick", 8'h30, 1'b0, 1'b0);

    // Borrow across digits.
    cyc(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, "ld10",      8'h10, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "start10",   8'h10, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "borrow",    8'h09, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "noteck",    8'h09, 1'b0, 1'b1);

    // Stop at zero.
    cyc(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, "ld03_tick", 8'h03, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "s0_start",  8'h03, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "s0_t1",     8'h02, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "s0_t2",     8'h01, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "s0_t3",     8'h00, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "s0_t4",     8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "done_strt", 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "done_tick", 8'h00, 1'b0, 1'b0);

    // Auto-reload.
    cyc(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, "ar_ld",     8'h03, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "ar_start",  8'h03, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "ar_t1",     8'h02, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "ar_t2",     8'h01, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "ar_t3",     8'h00, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "ar_t4",     8'h03, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "ar_t5",     8'h02, 1'b0, 1'b1);

    // Pause / resume, start+stop together.
    cyc(1'b0, 1'b1, 8'h25, 1'b0, 1'b0, 1'b0, 1'b0, "p_ld",      8'h25, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "p_start",   8'h25, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "p_t1",      8'h24, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "p_stop",    8'h24, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "p_hold",  8'h24, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "p_resume",  8'h24, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "p_t2",      8'h23, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, "ss_run",    8'h23, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "ss_pause",  8'h23, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "ss_hold",   8'h23, 1'b0, 1'b0);

    // Clamp on load.
    cyc(1'b0, 1'b1, 8'hFA, 1'b0, 1'b0, 1'b0, 1'b0, "clamp",     8'h99, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hB7, 1'b0, 1'b0, 1'b0, 1'b0, "clamp_hi",  8'h97, 1'b0, 1'b0);

    // Reset mid-run.
    cyc(1'b0, 1'b1, 8'h57, 1'b0, 1'b0, 1'b0, 1'b0, "r_ld",      8'h57, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "r_start",   8'h57, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "r_reset",   8'h30, 1'b0, 1'b0);

    // Reset on the tick that would expire suppresses the pulse.
    cyc(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, "re_ld",     8'h01, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "re_start",  8'h01, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "re_reset",  8'h30, 1'b0, 1'b0);

    // Load while running ignores the tick and returns to IDLE.
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "lr_start",  8'h30, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, "lr_load",   8'h42, 1'b0, 1'b0);

    // Zero count in RUN, auto-reload with reload value 0: stays 0, no pulse.
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, "z_ld",      8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "z_start",   8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "z_ar_t1",   8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "z_ar_t2",   8'h00, 1'b0, 1'b1);
    // Auto-reload dropped: next tick at zero goes to DONE without a pulse.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "z_done",    8'h00, 1'b0, 1'b0);

    if (sb.size() != 0) begin
      bad++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
